neuron_act_quant: RTL and testbench

//   Downstream stage of neuron: takes the 17-bit signed dot-product result, adds a per-neuron

---
 rtl/neuron_act_quant.sv | 101 ++++++++++
 tb/tb_neuron_act_quant.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_act_quant.sv
// Bias-add, ReLU, round-shift and int8 saturation stage after the neuron dot product.
// Optional feature: define LEAKY_RELU_EN for a 1/8-slope leaky ReLU with an active lower clamp.
module neuron_act_quant #(
    parameter int IN_W   = 17,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [BIAS_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    input  logic              clear_stats,
    output logic [15:0]       sat_count
);

    localparam int SUM_W = ((IN_W > BIAS_W + SHIFT) ? IN_W : BIAS_W + SHIFT) + 1;
    localparam int R_W   = SUM_W + 1;

    localparam logic signed [R_W-1:0] HALF    = R_W'((1 << SHIFT) >> 1);
    localparam logic signed [R_W-1:0] OUT_MAX = R_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] OUT_MIN = ~OUT_MAX;

    logic                    s1_v;
    logic signed [SUM_W-1:0] s1_sum;
    logic                    s1_adv;
    logic                    in_fire;

    logic signed [SUM_W-1:0] in_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W-1:0] sum_next;

    logic signed [SUM_W-1:0] act;
    logic signed [R_W-1:0]   act_ext;
    logic signed [R_W-1:0]   r;
    logic [OUT_W-1:0]        q;
    logic                    clamped;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_v || s1_adv);
    assign in_fire  = in_valid && in_ready;

    assign in_ext   = {{(SUM_W - IN_W){in_data[IN_W-1]}}, in_data};
    assign bias_ext = {{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias};
    assign sum_next = in_ext + (bias_ext <<< SHIFT);

    // Activation, round-half-up requantisation and clamp of the value sitting in S1.
    always_comb begin
        act = s1_sum;
`ifdef LEAKY_RELU_EN
        if (s1_sum[SUM_W-1]) act = s1_sum >>> 3;
`else
        if (s1_sum[SUM_W-1]) act = '0;
`endif
        act_ext = {act[SUM_W-1], act};
        r       = (act_ext + HALF) >>> SHIFT;
        q       = r[OUT_W-1:0];
        clamped = 1'b0;
        if (r > OUT_MAX) begin
            q       = OUT_MAX[OUT_W-1:0];
            clamped = 1'b1;
        end else if (r < OUT_MIN) begin
            q       = OUT_MIN[OUT_W-1:0];
            clamped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s1_sum    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else begin
            if (s1_adv) begin
                out_valid <= s1_v;
                if (s1_v) out_data <= q;
            end

            if (in_fire) begin
                s1_v   <= 1'b1;
                s1_sum <= sum_next;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            // Counts clamps as values enter S2, so a stalled output is never counted twice.
            if (clear_stats)
                sat_count <= '0;
            else if (s1_adv && s1_v && clamped && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_neuron_act_quant.sv
// Directed bench for neuron_act_quant: table of single-sample vectors plus
// backpressure, back-to-back, clear and reset sequences.
module tb_neuron_act_quant;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic [7:0]  bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        clear_stats;
    logic [15:0] sat_count;

    int total;
    int bad;
    int exp_sat;

    int vals [16];
    int got [$];
    int got_cyc [$];
    int ready_drops;

    typedef struct {
        string name;
        int    din;
        int    b;
        int    exp_q;
        int    sat;
    } vec_t;

    vec_t vecs [15];

    neuron_act_quant dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bias        (bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clear_stats (clear_stats),
        .sat_count   (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_vec(input int idx, input string name, input int din, input int b,
                           input int exp_q, input int sat);
        vecs[idx].name  = name;
        vecs[idx].din   = din;
        vecs[idx].b     = b;
        vecs[idx].exp_q = exp_q;
        vecs[idx].sat   = sat;
    endtask

    // Single sample through an idle pipeline; caller is positioned at a negedge.
    task automatic apply_stimulus(input string name, input int din, input int b,
                                  input int exp_q, input int sat);
        in_valid = 1'b1;
        in_data  = 17'(din);
        bias     = 8'(b);
        #1;
        check_output({name, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_output({name, "_early_valid"}, int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        exp_sat += sat;
        check_output({name, "_valid"}, int'(out_valid), 1);
        check_output({name, "_data"}, int'($signed(out_data)), exp_q);
        check_output({name, "_sat"}, int'(sat_count), exp_sat);
    endtask

    // Streams vals[0..n-1]; out_ready is held low for the first 'stall' cycles.
    task automatic run_stream(input int n, input int stall, input string tag);
        int sent;
        sent = 0;
        got.delete();
        got_cyc.delete();
        ready_drops = 0;
        for (int cyc = 0; cyc < 80 && got.size() < n; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            if (sent < n) in_data = 17'(vals[sent]);
            bias = 8'd0;
            #1;
            if (stall > 0 && cyc == 2) begin
                check_output({tag, "_accepts"}, sent, 2);
                check_output({tag, "_in_ready_low"}, int'(in_ready), 0);
            end
            if (stall > 0 && cyc >= 2 && cyc < stall) begin
                check_output({tag, "_held_valid"}, int'(out_valid), 1);
                check_output({tag, "_held_data"}, int'($signed(out_data)), 1);
            end
            if (out_valid && out_ready) begin
                got.push_back(int'($signed(out_data)));
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) sent++;
            else if (in_valid) ready_drops++;
        end
        in_valid = 1'b0;
        check_output({tag, "_count"}, got.size(), n);
        for (int i = 0; i < got.size(); i++)
            check_output($sformatf("%s_order%0d", tag, i), got[i], i + 1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        exp_sat     = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        bias        = '0;
        out_ready   = 1'b1;
        clear_stats = 1'b0;

        set_vec(0,  "t26",        26,     0,    7,   0);
        set_vec(1,  "t10b3",      10,     3,    6,   0);
        set_vec(3,  "big1000",    1000,   0,    127, 1);
        set_vec(4,  "half_up6",   6,      0,    2,   0);
        set_vec(5,  "half_up2",   2,      0,    1,   0);
        set_vec(6,  "below_half", 1,      0,    0,   0);
        set_vec(7,  "edge509",    509,    0,    127, 0);
        set_vec(8,  "edge510",    510,    0,    127, 1);
        set_vec(11, "maxpos",     65535,  127,  127, 1);
`ifdef LEAKY_RELU_EN
        set_vec(2,  "neg12",      -12,    0,    0,    0);
        set_vec(9,  "biasneg",    0,      -128, -16,  0);
        set_vec(10, "mixneg",     -1000,  127,  -15,  0);
        set_vec(12, "minneg",     -65536, -128, -128, 1);
        set_vec(13, "neg80",      -80,    0,    -2,   0);
        set_vec(14, "neg20000",   -20000, 0,    -128, 1);
`else
        set_vec(2,  "neg12",      -12,    0,    0,   0);
        set_vec(9,  "biasneg",    0,      -128, 0,   0);
        set_vec(10, "mixneg",     -1000,  127,  0,   0);
        set_vec(12, "minneg",     -65536, -128, 0,   0);
        set_vec(13, "neg80",      -80,    0,    0,   0);
        set_vec(14, "neg20000",   -20000, 0,    0,   0);
`endif

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_out_data", int'(out_data), 0);
        check_output("rst_sat", int'(sat_count), 0);
        check_output("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;

        foreach (vecs[i])
            apply_stimulus(vecs[i].name, vecs[i].din, vecs[i].b, vecs[i].exp_q, vecs[i].sat);

        clear_stats = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_stats = 1'b0;
        exp_sat     = 0;
        check_output("clear_sat", int'(sat_count), 0);

        // Clear lands on the same edge that loads a clamped value into S2.
        in_valid = 1'b1;
        in_data  = 17'd1000;
        bias     = 8'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        clear_stats = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_stats = 1'b0;
        check_output("clear_wins_sat", int'(sat_count), 0);
        check_output("clear_wins_data", int'($signed(out_data)), 127);

        for (int k = 0; k < 4; k++) vals[k] = 4 * (k + 1);
        run_stream(4, 6, "bp");

        for (int k = 0; k < 16; k++) vals[k] = 4 * (k + 1);
        run_stream(16, 0, "b2b");
        check_output("b2b_ready_drops", ready_drops, 0);
        for (int i = 0; i < got_cyc.size(); i++)
            check_output($sformatf("b2b_lag%0d", i), got_cyc[i], i + 2);

        // Fill both stages under backpressure, then reset.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 17'd1000;
        @(posedge clk);
        @(negedge clk);
        in_data = 17'd26;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_output("pre_rst_valid", int'(out_valid), 1);
        check_output("pre_rst_sat", int'(sat_count), 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 17'd500;
        #1;
        check_output("mid_rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check_output("mid_rst_valid", int'(out_valid), 0);
        check_output("mid_rst_data", int'(out_data), 0);
        check_output("mid_rst_sat", int'(sat_count), 0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_sat   = 0;
        @(posedge clk);
        @(negedge clk);
        check_output("post_rst_idle", int'(out_valid), 0);
        apply_stimulus("post_rst", 26, 0, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
